rf_seq_ctrl: RTL and testbench

//  Sequencer for the 8x8 systolic-array register file and PE array. On START it clears
//  the PE accumulators and loads N rows of X/W operands into the RF via a valid/ready

---
 rtl/rf_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_rf_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_seq_ctrl.sv
// Job sequencer for the systolic-array register file and PE array:
// clear accumulators, load N operand rows by handshake, shift/compute, then flag DONE.
module rf_seq_ctrl #(
    parameter int N           = 8,
    parameter int IDXW        = 3,
    parameter int COMPUTE_CYC = 3*N-2,
    parameter int CNTW        = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    output logic            rf_en_o,
    output logic            rf_write_o,
    output logic [IDXW-1:0] rf_idx_o,
    output logic            array_clr_o,
    output logic            array_en_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [CNTW-1:0] cyc_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD    = 3'd2,
        S_COMPUTE = 3'd3,
        S_FIN     = 3'd4
    } state_e;

    localparam logic [IDXW-1:0] ROW_LAST = IDXW'(N-1);
    localparam logic [CNTW-1:0] CYC_LAST = CNTW'(COMPUTE_CYC-1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] row_cnt_q, row_cnt_d;
    logic [CNTW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic            accept_s;

    // ABORT outranks the handshake, so an aborted row is never written.
    assign accept_s = (state_q == S_LOAD) && ld_valid_i && !abort_i;

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            row_cnt_q <= {IDXW{1'b0}};
            cyc_cnt_q <= {CNTW{1'b0}};
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        if (abort_i) begin
            state_d   = S_IDLE;
            row_cnt_d = {IDXW{1'b0}};
            cyc_cnt_d = {CNTW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    row_cnt_d = {IDXW{1'b0}};
                    cyc_cnt_d = {CNTW{1'b0}};
                    if (start_i) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    row_cnt_d = {IDXW{1'b0}};
                    state_d   = S_LOAD;
                end
                S_LOAD: begin
                    if (accept_s) begin
                        if (row_cnt_q == ROW_LAST) begin
                            state_d   = S_COMPUTE;
                            cyc_cnt_d = {CNTW{1'b0}};
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_COMPUTE: begin
                    if (cyc_cnt_q == CYC_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 1'b1;
                    end
                end
                S_FIN: begin
                    state_d   = S_IDLE;
                    row_cnt_d = {IDXW{1'b0}};
                    cyc_cnt_d = {CNTW{1'b0}};
                end
                default: begin
                    state_d   = S_IDLE;
                    row_cnt_d = {IDXW{1'b0}};
                    cyc_cnt_d = {CNTW{1'b0}};
                end
            endcase
        end
    end

    // Output decode; only RF_EN in LOAD looks at the live handshake inputs.
    always_comb begin
        ld_ready_o  = 1'b0;
        rf_en_o     = 1'b0;
        rf_write_o  = 1'b0;
        rf_idx_o    = {IDXW{1'b0}};
        array_clr_o = 1'b0;
        array_en_o  = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        cyc_cnt_o   = {CNTW{1'b0}};
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
            end
            S_CLEAR: begin
                array_clr_o = 1'b1;
                busy_o      = 1'b1;
            end
            S_LOAD: begin
                ld_ready_o = 1'b1;
                rf_en_o    = accept_s;
                rf_write_o = 1'b1;
                rf_idx_o   = row_cnt_q;
                busy_o     = 1'b1;
            end
            S_COMPUTE: begin
                rf_en_o    = 1'b1;
                array_en_o = 1'b1;
                busy_o     = 1'b1;
                cyc_cnt_o  = cyc_cnt_q;
            end
            S_FIN: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Self-checking bench for rf_seq_ctrl: randomized jobs compared cycle by cycle
// against an expected job timeline built from the sequencing rules.
module tb_rf_seq_ctrl;

    localparam int N   = 8;
    localparam int CCY = 3*N-2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, ld_valid;
    logic       ld_ready, rf_en, rf_write, array_clr, array_en, busy, done;
    logic [2:0] rf_idx;
    logic [4:0] cyc_cnt;
    logic [14:0] obs;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    rf_seq_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .abort_i    (abort),
        .ld_valid_i (ld_valid),
        .ld_ready_o (ld_ready),
        .rf_en_o    (rf_en),
        .rf_write_o (rf_write),
        .rf_idx_o   (rf_idx),
        .array_clr_o(array_clr),
        .array_en_o (array_en),
        .busy_o     (busy),
        .done_o     (done),
        .cyc_cnt_o  (cyc_cnt)
    );

    // {ld_ready, rf_en, rf_write, rf_idx, array_clr, array_en, busy, done, cyc_cnt}
    assign obs = {ld_ready, rf_en, rf_write, rf_idx, array_clr, array_en, busy, done, cyc_cnt};

    // One job as a timeline: start cycle, clear, rows until N accepts, CCY compute, fin.
    // mode: 0 valid always, 1 pattern 1,0,0 repeating, 2 random.
    // abort_row: abort (with valid=1) when that many rows are loaded; rst_k: reset in compute cycle k.
    task automatic drive_job(input int mode, input int abort_row, input int rst_k,
                             input bit noise, output int lat);
        int rows;
        int guard;
        logic v;
        logic ab;
        logic [14:0] exp;
        logic [2:0] ri;
        logic [4:0] kk;
        lat = 0;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; ld_valid = 1'($urandom); #1;
        n_checks++;
        if (obs !== 15'd0) begin
            n_err++; $display("FAIL idle_start: got %h expected %h", obs, 15'd0);
        end
        lat++;
        @(negedge clk);
        start = noise ? 1'($urandom) : 1'b0; ld_valid = 1'($urandom); #1;
        exp = {1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
        n_checks++;
        if (obs !== exp) begin
            n_err++; $display("FAIL clear: got %h expected %h", obs, exp);
        end
        lat++;
        rows = 0; guard = 0;
        while (rows < N) begin
            @(negedge clk);
            start = noise ? 1'($urandom) : 1'b0;
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (guard % 3 == 0);
            else v = 1'($urandom_range(0, 1));
            ab = (rows == abort_row);
            if (ab) v = 1'b1;
            ld_valid = v; abort = ab; #1;
            ri = rows[2:0];
            exp = {1'b1, v & ~ab, 1'b1, ri, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
            n_checks++;
            if (obs !== exp) begin
                n_err++; $display("FAIL load row %0d: got %h expected %h", rows, obs, exp);
            end
            lat++;
            if (ab) begin
                @(negedge clk);
                abort = 1'b0; ld_valid = 1'b0; start = 1'b0; #1;
                n_checks++;
                if (obs !== 15'd0) begin
                    n_err++; $display("FAIL abort_idle: got %h expected %h", obs, 15'd0);
                end
                return;
            end
            if (v) rows++;
            guard++;
            if (guard > 300) begin
                n_checks++; n_err++;
                $display("FAIL load_timeout: got %0d rows expected %0d", rows, N);
                return;
            end
        end
        for (int k = 0; k < CCY; k++) begin
            @(negedge clk);
            start = noise ? 1'($urandom) : 1'b0; ld_valid = 1'($urandom); #1;
            kk = k[4:0];
            exp = {1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, kk};
            n_checks++;
            if (obs !== exp) begin
                n_err++; $display("FAIL compute %0d: got %h expected %h", k, obs, exp);
            end
            lat++;
            if (k == rst_k) begin
                rst_n = 1'b0; #1;
                n_checks++;
                if (obs !== 15'd0) begin
                    n_err++; $display("FAIL reset_async: got %h expected %h", obs, 15'd0);
                end
                @(negedge clk);
                start = 1'b0; rst_n = 1'b1; #1;
                n_checks++;
                if (obs !== 15'd0) begin
                    n_err++; $display("FAIL reset_release: got %h expected %h", obs, 15'd0);
                end
                return;
            end
        end
        @(negedge clk);
        start = noise ? 1'b1 : 1'b0; #1;
        exp = {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0};
        n_checks++;
        if (obs !== exp) begin
            n_err++; $display("FAIL fin: got %h expected %h", obs, exp);
        end
        lat++;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            start = 1'b0; ld_valid = 1'($urandom); #1;
            n_checks++;
            if (obs !== 15'd0) begin
                n_err++; $display("FAIL after_fin %0d: got %h expected %h", j, obs, 15'd0);
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0;
        #1;
        n_checks++;
        if (obs !== 15'd0) begin
            n_err++; $display("FAIL reset_state: got %h expected %h", obs, 15'd0);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        drive_job(0, -1, 10, 1'b0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        drive_job(0, -1, -1, 1'b0, lat);
        n_checks++;
        if (lat !== 33) begin
            n_err++; $display("FAIL b2b_latency: got %0d expected %0d", lat, 33);
        end
    endtask

    task automatic test_gapped();
        int lat;
        drive_job(1, -1, -1, 1'b0, lat);
        // accepts at load cycles 0,3,..,21 -> 22 load cycles
        n_checks++;
        if (lat !== 1 + 1 + 22 + CCY + 1) begin
            n_err++; $display("FAIL gapped_latency: got %0d expected %0d", lat, 47);
        end
    endtask

    task automatic test_abort();
        int lat;
        drive_job(0, 3, -1, 1'b0, lat);
        drive_job(0, -1, -1, 1'b0, lat);
        n_checks++;
        if (lat !== 33) begin
            n_err++; $display("FAIL restart_latency: got %0d expected %0d", lat, 33);
        end
    endtask

    task automatic test_start_busy();
        int lat;
        for (int i = 0; i < 3; i++) begin
            drive_job(2, -1, -1, 1'b1, lat);
        end
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 6; i++) begin
            drive_job(2, $urandom_range(0, 12), -1, 1'($urandom), lat);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_abort();
        test_start_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
